ultrasonic_scheduler: RTL and testbench
=======================================

# ultrasonic_scheduler

Round-robin ping scheduler for a bank of HC-SR04-style ultrasonic sensors, sitting between the sensors' trigger/echo pins and the Nios read port. It owns every sensor's trigger, fires one sensor at a time, and measures the echo pulse width in clock cycles. A guard interval between pings prevents acoustic crosstalk. The latest result per sensor is kept in a small result bank that software reads by index.

## Interface
- `N_SENSORS`, 4: number of sensors, 1..8.
- `TRIG_CYCLES`, 500: trigger pulse width in cycles (10 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_600_000: limit for both echo wait and echo width. Must be ≤ 2^24−1.
- `GUARD_CYCLES`, 65_536: idle cycles after each ping before the next trigger.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: run the schedule.
- `echo`, in, N_SENSORS: echo pins, asynchronous.
- `trigger`, out, N_SENSORS: trigger pins, one-hot or zero.
- `rd_en`, in, 1: read strobe.
- `rd_addr`, in, 3: sensor index to read.
- `read_data`, out, 32: result word.
- `read_data_valid`, out, 1: `read_data` valid this cycle.
- `sample_valid`, out, 1: one-cycle pulse when a slot is written.
- `sample_id`, out, 3: index of the slot just written.

## Operation
- States:
  - IDLE: if `enable`, go to TRIG for sensor `cur`.
  - TRIG: drive `trigger[cur]` for exactly TRIG_CYCLES cycles, then go to WAIT.
  - WAIT: on an echo rising edge (sample low, then high), go to MEAS. If the wait counter reaches TIMEOUT_CYCLES, store a timeout result with count 0 and go to GUARD.
  - MEAS: increment the 24-bit count on every cycle echo is sampled high. On echo sampled low, store the count and go to GUARD. If the count reaches TIMEOUT_CYCLES, store the saturated count with the timeout bit set and go to GUARD.
  - GUARD: wait GUARD_CYCLES. Then advance `cur` (N_SENSORS−1 wraps to 0). Go to TRIG if `enable`, else IDLE.
- Dropping `enable` mid-ping does not abort the ping: the current ping and its guard complete first.
- A stuck-high echo produces no rising edge, so it ends in a WAIT timeout.
- Result word layout:
  - [31] timeout
  - [30] fresh
  - [29:24] zero
  - [23:0] echo width in cycles
- Read rules:
  - A read of a slot returns its word and clears that slot's fresh bit.
  - `rd_addr` ≥ N_SENSORS returns 0.
  - If a store and a read hit the same slot in the same cycle, the read returns the old word and fresh stays set.

## Timing
- Reset values:
  - All outputs 0.
  - All slots 0.
  - `cur` = 0, state IDLE.
  - Reset mid-ping drops `trigger` at the next edge and discards the partial count.
- `enable` sampled high in IDLE at edge t → `trigger[cur]` high from t+1 through t+TRIG_CYCLES.
- Echo high for W cycles, with no synchronizer → stored count W.
- Slot write and `sample_valid` occur at the same edge.
- The stored value is readable with `rd_en` on the following cycle.
- `read_data_valid` and `read_data` appear exactly one cycle after `rd_en`, with no back-pressure.
- Trigger-to-trigger spacing is deterministic only between two timeout pings.

## Configuration
- `ULTRASONIC_ECHO_SYNC_EN` defined: each `echo` bit passes through a two-flop synchronizer before edge detection. This adds 2 cycles of latency to echo start and end; the width count is unchanged.
- Undefined: echo is sampled directly by a single register, which is used for edge detection only. This is for simulation or for pins already synchronized upstream.

## Structure
- `ultrasonic_pkg` holds:
  - the state enum;
  - result bit positions (`RES_TIMEOUT_BIT`, `RES_FRESH_BIT`, `RES_COUNT_W`=24);
  - the result struct typedef.
- Sub-module `ultrasonic_result_bank`: N_SENSORS result slots, write port, registered read port, fresh-bit handling.
- The scheduler FSM and counters live in the top module.

## Test plan
Parameters for all scenarios: N_SENSORS=2, TRIG=10, TIMEOUT=1000, GUARD=50, sync undefined.
- Reset held, then `enable`=0 for 20 cycles → `trigger`=0, `sample_valid`=0, a read of slot 0 returns 0x00000000.
- `enable`=1, echo[0] high 300 cycles after trigger → `trigger[0]` high exactly 10 cycles, `sample_id`=0 pulse. A read of slot 0 returns 0x4000012C; a second read returns 0x0000012C.
- echo[1] never rises → after 1000 WAIT cycles, slot 1 = 0xC0000000.
- echo[0] high 2000 cycles → slot 0 = 0xC00003E8, then GUARD.
- Continuous `enable` → triggers fire in order 0,1,0 with ≥ 50 idle cycles between pings. Reset asserted during MEAS → `trigger` 0 next cycle, slots 0, next ping is sensor 0.
- `rd_en` on slot 0 in the same cycle as its store → returns the old word; the next read returns the new word with fresh=1.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types for the ultrasonic ping scheduler.
// Holds the FSM state encoding and the packed result word layout.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_MEAS,
        ST_GUARD
    } state_t;

    localparam int RES_TIMEOUT_BIT = 31;
    localparam int RES_FRESH_BIT   = 30;
    localparam int RES_COUNT_W     = 24;

    typedef struct packed {
        logic                   timeout;
        logic                   fresh;
        logic [5:0]             zero;
        logic [RES_COUNT_W-1:0] count;
    } result_t;

    // Every stored result starts out fresh; software clears it by reading.
    function automatic result_t make_result(input logic timeout, input logic [RES_COUNT_W-1:0] count);
        result_t r;
        r                  = '0;
        r[RES_TIMEOUT_BIT] = timeout;
        r[RES_FRESH_BIT]   = 1'b1;
        r.count            = count;
        return r;
    endfunction

endpackage

// File: rtl/ultrasonic_result_bank.sv
// Per-sensor result slots with one write port and a registered read port.
// A read clears the slot's fresh bit unless a store to the same slot lands in that cycle.
module ultrasonic_result_bank
    import ultrasonic_pkg::*;
#(
    parameter int N_SENSORS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [2:0]  rd_addr,
    output logic [31:0] read_data,
    output logic        read_data_valid
);

    result_t slots [N_SENSORS];
    logic    rd_hit;
    result_t rd_word;

    always_comb begin
        // NOTE: defaults assigned first so every path drives every output -- no latch.
        rd_hit  = 1'b0;
        rd_word = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (rd_addr == 3'(i)) begin
                rd_hit  = 1'b1;
                rd_word = slots[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: slots are plain flops, reset explicitly so a read after reset returns zero.
            for (int i = 0; i < N_SENSORS; i++) begin
                slots[i] <= '0;
            end
            read_data       <= '0;
            read_data_valid <= 1'b0;
        end else begin
            read_data_valid <= rd_en;
            read_data       <= (rd_en && rd_hit) ? rd_word : '0;
            // The store is written last so it wins over the fresh-bit clear.
            for (int i = 0; i < N_SENSORS; i++) begin
                if (rd_en && rd_addr == 3'(i)) begin
                    slots[i][RES_FRESH_BIT] <= 1'b0;
                end
                if (wr_en && wr_idx == 3'(i)) begin
                    slots[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 ping scheduler: trigger, echo-width measurement, guard interval.
// Define ULTRASONIC_ECHO_SYNC_EN to pass each echo pin through a two-flop synchronizer.
module ultrasonic_scheduler
    import ultrasonic_pkg::*;
#(
    parameter int N_SENSORS      = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_600_000,
    parameter int GUARD_CYCLES   = 65_536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trigger,
    input  logic                 rd_en,
    input  logic [2:0]           rd_addr,
    output logic [31:0]          read_data,
    output logic                 read_data_valid,
    output logic                 sample_valid,
    output logic [2:0]           sample_id
);

    localparam int CW = RES_COUNT_W;
    localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);

    state_t               state;
    logic [2:0]           cur;
    logic [2:0]           next_cur;
    logic [CW-1:0]        cnt;
    logic [N_SENSORS-1:0] echo_s;
    logic [N_SENSORS-1:0] echo_q;
    logic                 echo_now;
    logic                 echo_prev;
    logic                 echo_rise;
    logic                 store_en;
    result_t              store_word;

`ifdef ULTRASONIC_ECHO_SYNC_EN
    logic [N_SENSORS-1:0] echo_m1;
    logic [N_SENSORS-1:0] echo_m2;

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_m1 <= '0;
            echo_m2 <= '0;
        end else begin
            echo_m1 <= echo;
            echo_m2 <= echo_m1;
        end
    end

    assign echo_s = echo_m2;
`else
    assign echo_s = echo;
`endif

    function automatic logic [N_SENSORS-1:0] onehot(input logic [2:0] idx);
        logic [N_SENSORS-1:0] r;
        r = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (idx == 3'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign next_cur = (cur == 3'(N_SENSORS - 1)) ? 3'd0 : cur + 3'd1;

    // Echo selection and the store decision; the slot write shares the sample_valid edge.
    always_comb begin
        echo_now   = 1'b0;
        echo_prev  = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (cur == 3'(i)) begin
                echo_now  = echo_s[i];
                echo_prev = echo_q[i];
            end
        end
        echo_rise  = echo_now & ~echo_prev;
        store_en   = 1'b0;
        store_word = '0;
        case (state)
            ST_WAIT: begin
                if (!echo_rise && cnt == TIMEOUT_LAST) begin
                    store_en   = 1'b1;
                    store_word = make_result(1'b1, '0);
                end
            end
            ST_MEAS: begin
                if (!echo_now) begin
                    store_en   = 1'b1;
                    store_word = make_result(1'b0, cnt);
                end else if (cnt == TIMEOUT_MAX) begin
                    store_en   = 1'b1;
                    store_word = make_result(1'b1, cnt);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur          <= '0;
            cnt          <= '0;
            trigger      <= '0;
            sample_valid <= 1'b0;
            sample_id    <= '0;
            echo_q       <= '0;
        end else begin
            echo_q       <= echo_s;
            sample_valid <= store_en;
            if (store_en) sample_id <= cur;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_TRIG;
                        trigger <= onehot(cur);
                        cnt     <= '0;
                    end
                end
                ST_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state   <= ST_WAIT;
                        trigger <= '0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT: begin
                    // The rising-edge cycle is the first high cycle, so counting starts at 1.
                    if (echo_rise) begin
                        state <= ST_MEAS;
                        cnt   <= CW'(1);
                    end else if (store_en) begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_MEAS: begin
                    if (store_en) begin
                        state <= ST_GUARD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        cur <= next_cur;
                        cnt <= '0;
                        if (enable) begin
                            state   <= ST_TRIG;
                            trigger <= onehot(next_cur);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ultrasonic_result_bank #(
        .N_SENSORS(N_SENSORS)
    ) u_bank (
        .clk             (clk),
        .reset           (reset),
        .wr_en           (store_en),
        .wr_idx          (cur),
        .wr_data         (store_word),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .read_data       (read_data),
        .read_data_valid (read_data_valid)
    );

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler: two sensors, short trigger/timeout/guard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ultrasonic_scheduler;

    localparam int N       = 2;
    localparam int TRIG    = 10;
    localparam int TIMEOUT = 1000;
    localparam int GUARD   = 50;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] echo;
    logic [N-1:0] trigger;
    logic         rd_en;
    logic [2:0]   rd_addr;
    logic [31:0]  read_data;
    logic         read_data_valid;
    logic         sample_valid;
    logic [2:0]   sample_id;

    int n_checks = 0;
    int n_errors = 0;

    ultrasonic_scheduler #(
        .N_SENSORS      (N),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TIMEOUT),
        .GUARD_CYCLES   (GUARD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .echo            (echo),
        .trigger         (trigger),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .sample_valid    (sample_valid),
        .sample_id       (sample_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick();
        rd_en   = 1'b0;
        check({tag, "_valid"}, 32'(read_data_valid), 32'd1);
        check(tag, read_data, exp);
    endtask

    // Waits for a trigger, checks which sensor fired and the pulse width; returns cycles waited.
    task automatic ping_trigger(input string tag, input logic [N-1:0] exp, output int gap);
        int w;
        gap = 0;
        while (trigger == '0 && gap < 200) begin
            tick();
            gap++;
        end
        check({tag, "_order"}, 32'(trigger), 32'(exp));
        w = 0;
        while (trigger == exp && w < 100) begin
            tick();
            w++;
        end
        check({tag, "_width"}, 32'(w), 32'(TRIG));
    endtask

    task automatic wait_sample(input string tag, input int budget, output int waited);
        waited = 0;
        while (!sample_valid && waited < budget) begin
            tick();
            waited++;
        end
        check({tag, "_seen"}, 32'(sample_valid), 32'd1);
    endtask

    initial begin
        int gap;
        int waited;
        int bad;

        reset   = 1'b1;
        enable  = 1'b0;
        echo    = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        repeat (5) tick();
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_sample_id", 32'(sample_id), 32'd0);
        check("rst_rd_valid", 32'(read_data_valid), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        reset = 1'b0;

        bad = 0;
        repeat (20) begin
            tick();
            if (trigger != '0 || sample_valid) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        do_read(3'd0, 32'h0000_0000, "rd_slot0_reset");

        // Ping 0: 300-cycle echo.
        enable = 1'b1;
        ping_trigger("p0", 2'b01, gap);
        echo[0] = 1'b1;
        repeat (300) tick();
        echo[0] = 1'b0;
        wait_sample("p0_sample", 50, waited);
        check("p0_id", 32'(sample_id), 32'd0);
        do_read(3'd0, 32'h4000_012C, "rd_p0_first");
        do_read(3'd0, 32'h0000_012C, "rd_p0_second");

        // Ping 1: echo never rises.
        ping_trigger("p1", 2'b10, gap);
        wait_sample("p1_sample", 1200, waited);
        check("p1_wait_len", 32'(waited), 32'(TIMEOUT));
        check("p1_id", 32'(sample_id), 32'd1);

        // Ping 2: echo held well past the timeout.
        ping_trigger("p2", 2'b01, gap);
        check("p2_guard_gap", 32'(gap), 32'(GUARD));
        echo[0] = 1'b1;
        wait_sample("p2_sample", 1500, waited);
        check("p2_id", 32'(sample_id), 32'd0);
        ping_trigger("p3", 2'b10, gap);
        check("p3_guard_gap", 32'(gap), 32'(GUARD));
        echo[0] = 1'b0;
        do_read(3'd0, 32'hC000_03E8, "rd_p2_sat");
        do_read(3'd1, 32'hC000_0000, "rd_p1_timeout");
        wait_sample("p3_sample", 1200, waited);
        check("p3_id", 32'(sample_id), 32'd1);

        // Ping 4: reset lands while measuring.
        ping_trigger("p4", 2'b01, gap);
        echo[0] = 1'b1;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        check("rst_meas_trigger", 32'(trigger), 32'd0);
        check("rst_meas_sample_valid", 32'(sample_valid), 32'd0);
        echo[0] = 1'b0;
        reset   = 1'b0;
        enable  = 1'b0;
        do_read(3'd0, 32'h0000_0000, "rd_slot0_after_rst");
        do_read(3'd1, 32'h0000_0000, "rd_slot1_after_rst");

        // Restart: first ping must be sensor 0 again.
        enable = 1'b1;
        ping_trigger("p5", 2'b01, gap);
        echo[0] = 1'b1;
        repeat (5) tick();
        echo[0] = 1'b0;
        wait_sample("p5_sample", 50, waited);
        check("p5_id", 32'(sample_id), 32'd0);
        ping_trigger("p6", 2'b10, gap);
        wait_sample("p6_sample", 1200, waited);
        check("p6_id", 32'(sample_id), 32'd1);

        // Ping 7: enable dropped mid-ping, read collides with the store.
        ping_trigger("p7", 2'b01, gap);
        enable  = 1'b0;
        echo[0] = 1'b1;
        repeat (7) tick();
        echo[0] = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 3'd0;
        tick();
        rd_en   = 1'b0;
        check("collide_sample_valid", 32'(sample_valid), 32'd1);
        check("collide_sample_id", 32'(sample_id), 32'd0);
        check("collide_old_word", read_data, 32'h4000_0005);
        do_read(3'd0, 32'h4000_0007, "rd_after_collide");
        do_read(3'd2, 32'h0000_0000, "rd_out_of_range");

        bad = 0;
        repeat (100) begin
            tick();
            if (trigger != '0) bad++;
        end
        check("idle_after_disable", 32'(bad), 32'd0);

        // Reset during a trigger pulse drops the pin at the next edge.
        enable = 1'b1;
        waited = 0;
        while (trigger == '0 && waited < 10) begin
            tick();
            waited++;
        end
        check("p8_order", 32'(trigger), 32'b10);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_trig_trigger", 32'(trigger), 32'd0);
        reset  = 1'b0;
        enable = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
